gated_capture_bank: RTL and testbench

- Parametrised, fully clocked successor to the single-bit gated latch with clear: CHANNELS independent WIDTH-bit gated capture registers.
- Each channel has a per-channel gate and a level or edge capture mode.
- Each channel holds its value with a valid/acknowledge handshake and flags overruns.
- Sits between asynchronous-style gated sources and synchronous consumers. Replaces latch inference with flops on one clock.

---
 rtl/gated_capture_bank_pkg.sv | 12 +
 rtl/gated_capture_channel.sv | 53 +++++
 rtl/gated_capture_bank.sv | 40 ++++
 tb/tb_gated_capture_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gated_capture_bank_pkg.sv
// gated_capture_bank_pkg: shared capture-mode constants and channel packing helper
package gated_capture_bank_pkg;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;

    // Low bit index of channel idx inside a packed CHANNELS*WIDTH bus
    function automatic int chan_slice(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/gated_capture_channel.sv
// gated_capture_channel: one clocked gated capture register with valid/ack handshake and sticky overrun
module gated_capture_channel
    import gated_capture_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = MODE_LEVEL
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             g_i,
    input  logic             freeze_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             ovr_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             g_q, valid_q, valid_d, ovr_q, ovr_d;
    logic             rise, fall, load, evt;

    // Decode load and data-ready event from the gate and its one-cycle history
    always_comb begin
        rise    = g_i & ~g_q & ~freeze_i;
        fall    = g_q & ~g_i & ~freeze_i;
        load    = (EDGE_MODE == MODE_EDGE) ? rise : g_i & ~freeze_i;
        evt     = (EDGE_MODE == MODE_EDGE) ? rise : fall;
        q_d     = load ? d_i : q_q;
        valid_d = evt | (valid_q & ~ack_i);
        ovr_d   = ovr_q | (evt & valid_q & ~ack_i);
    end

    // Channel state; the gate history keeps tracking even while frozen so held gates never look like new edges
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q     <= '0;
            g_q     <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            g_q     <= g_i;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q_o     = q_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/gated_capture_bank.sv
// gated_capture_bank: CHANNELS independent clocked gated capture registers on one clock
module gated_capture_bank
    import gated_capture_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int EDGE_MODE = MODE_LEVEL
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       G,
    input  logic                      FREEZE,
    input  logic [CHANNELS-1:0]       ACK,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       VALID,
    output logic [CHANNELS-1:0]       OVR,
    output logic                      ANY_VALID
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        gated_capture_channel #(
            .WIDTH    (WIDTH),
            .EDGE_MODE(EDGE_MODE)
        ) u_chan (
            .clk_i   (CLK),
            .clr_i   (CLR),
            .d_i     (D[chan_slice(i, WIDTH) +: WIDTH]),
            .g_i     (G[i]),
            .freeze_i(FREEZE),
            .ack_i   (ACK[i]),
            .q_o     (Q[chan_slice(i, WIDTH) +: WIDTH]),
            .valid_o (VALID[i]),
            .ovr_o   (OVR[i])
        );
    end

    assign ANY_VALID = |VALID;

endmodule

// File: tb/tb_gated_capture_bank.sv
// tb_gated_capture_bank: scoreboard bench driving a level-mode and an edge-mode bank side by side
module tb_gated_capture_bank;
    import gated_capture_bank_pkg::*;

    typedef struct {
        logic        clr;
        logic [3:0]  g;
        logic [31:0] d;
        logic        frz;
        logic [3:0]  ack;
        logic [1:0]  chk;
        logic [31:0] q;
        logic [3:0]  v;
        logic [3:0]  o;
    } step_t;

    typedef struct {
        string       tag;
        bit          is_edge;
        logic [31:0] q;
        logic [3:0]  v;
        logic [3:0]  o;
    } exp_t;

    localparam logic [1:0] L = 2'b01, E = 2'b10, B = 2'b11;

    logic        clk = 1'b0;
    logic        clr = 1'b1, frz = 1'b0;
    logic [31:0] d = '0;
    logic [3:0]  g = '0, ack = '0;
    logic [31:0] ql, qe;
    logic [3:0]  vl, ve, ol, oe;
    logic        avl, ave;

    step_t stim[$];
    exp_t  sb[$];
    int    n_assert = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    gated_capture_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(MODE_LEVEL)) dut_l (
        .CLK(clk), .CLR(clr), .D(d), .G(g), .FREEZE(frz), .ACK(ack),
        .Q(ql), .VALID(vl), .OVR(ol), .ANY_VALID(avl)
    );

    gated_capture_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(MODE_EDGE)) dut_e (
        .CLK(clk), .CLR(clr), .D(d), .G(g), .FREEZE(frz), .ACK(ack),
        .Q(qe), .VALID(ve), .OVR(oe), .ANY_VALID(ave)
    );

    task automatic st(input logic c, input logic [3:0] gg, input logic [31:0] dd, input logic f,
                      input logic [3:0] a, input logic [1:0] k, input logic [31:0] q,
                      input logic [3:0] v, input logic [3:0] o);
        stim.push_back('{c, gg, dd, f, a, k, q, v, o});
    endtask

    task automatic apply(input string name, input int idx);
        step_t s = stim.pop_front();
        clr = s.clr;
        g   = s.g;
        d   = s.d;
        frz = s.frz;
        ack = s.ack;
        if (s.chk[0]) sb.push_back('{$sformatf("%s_lvl[%0d]", name, idx), 1'b0, s.q, s.v, s.o});
        if (s.chk[1]) sb.push_back('{$sformatf("%s_edg[%0d]", name, idx), 1'b1, s.q, s.v, s.o});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, B, 32'h0, 4'h0, 4'h0);
        st(1, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, B, 32'h0, 4'h0, 4'h0);
        st(0, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, E, 32'hFFFF_FFFF, 4'hF, 4'h0);
        st(0, 4'hF, 32'hFFFF_FFFF, 0, 4'h0, L, 32'hFFFF_FFFF, 4'h0, 4'h0);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("reset", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    task automatic test_level;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'h0, 32'h0, 0, 4'h0, L, 32'h0, 4'h0, 4'h0);
        st(0, 4'h1, 32'h11, 0, 4'h0, L, 32'h11, 4'h0, 4'h0);
        st(0, 4'h1, 32'h22, 0, 4'h0, L, 32'h22, 4'h0, 4'h0);
        st(0, 4'h1, 32'h33, 0, 4'h0, L, 32'h33, 4'h0, 4'h0);
        st(0, 4'h0, 32'h44, 0, 4'h0, L, 32'h33, 4'h1, 4'h0);
        st(0, 4'h0, 32'h55, 0, 4'h0, L, 32'h33, 4'h1, 4'h0);
        st(0, 4'h1, 32'h77, 0, 4'h0, L, 32'h77, 4'h1, 4'h0);
        st(0, 4'h0, 32'h00, 0, 4'h0, L, 32'h77, 4'h1, 4'h1);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("level", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    task automatic test_edge;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'h0, 32'h0, 0, 4'h0, E, 32'h0, 4'h0, 4'h0);
        st(0, 4'h1, 32'h0000_0012, 0, 4'h0, E, 32'h0000_0012, 4'h1, 4'h0);
        st(0, 4'h0, 32'h0000_0099, 0, 4'h0, E, 32'h0000_0012, 4'h1, 4'h0);
        st(0, 4'h4, 32'h00A5_0099, 0, 4'h0, E, 32'h00A5_0012, 4'h5, 4'h0);
        for (int k = 0; k < 4; k++) st(0, 4'h4, 32'h005A_0099, 0, 4'h0, E, 32'h00A5_0012, 4'h5, 4'h0);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("edge", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    task automatic test_overrun;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'h0, 32'h0, 0, 4'h0, E, 32'h0, 4'h0, 4'h0);
        st(0, 4'h1, 32'h0000_0001, 0, 4'h0, E, 32'h0000_0001, 4'h1, 4'h0);
        st(0, 4'h0, 32'h0000_0000, 0, 4'h0, E, 32'h0000_0001, 4'h1, 4'h0);
        st(0, 4'h1, 32'h0000_0002, 0, 4'h1, E, 32'h0000_0002, 4'h1, 4'h0);
        st(0, 4'h2, 32'h0000_1100, 0, 4'h0, E, 32'h0000_1102, 4'h3, 4'h0);
        st(0, 4'h0, 32'h0000_0000, 0, 4'h0, E, 32'h0000_1102, 4'h3, 4'h0);
        st(0, 4'h2, 32'h0000_3C00, 0, 4'h0, E, 32'h0000_3C02, 4'h3, 4'h2);
        st(0, 4'h0, 32'h0000_0000, 0, 4'h2, E, 32'h0000_3C02, 4'h1, 4'h2);
        st(0, 4'h0, 32'h0000_0000, 0, 4'h2, E, 32'h0000_3C02, 4'h1, 4'h2);
        st(0, 4'h2, 32'h0000_4D00, 0, 4'h2, E, 32'h0000_4D02, 4'h3, 4'h2);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("overrun", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    task automatic test_freeze;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'h0, 32'h0, 0, 4'h0, E, 32'h0, 4'h0, 4'h0);
        st(0, 4'h8, 32'h1000_0000, 0, 4'h0, E, 32'h1000_0000, 4'h8, 4'h0);
        st(0, 4'h0, 32'h0000_0000, 0, 4'h8, E, 32'h1000_0000, 4'h0, 4'h0);
        st(0, 4'h8, 32'h7700_0000, 1, 4'h0, E, 32'h1000_0000, 4'h0, 4'h0);
        st(0, 4'h8, 32'h7700_0000, 0, 4'h0, E, 32'h1000_0000, 4'h0, 4'h0);
        st(0, 4'h8, 32'h8800_0000, 0, 4'h0, E, 32'h1000_0000, 4'h0, 4'h0);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("freeze", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        logic [31:0] oq;
        logic [3:0] ov, oo;
        logic oa;
        st(1, 4'h0, 32'h0, 0, 4'h0, L, 32'h0, 4'h0, 4'h0);
        st(0, 4'h1, 32'h55, 0, 4'h0, L, 32'h55, 4'h0, 4'h0);
        st(1, 4'h1, 32'h55, 0, 4'h0, L, 32'h00, 4'h0, 4'h0);
        st(0, 4'h1, 32'h66, 0, 4'h0, L, 32'h66, 4'h0, 4'h0);
        for (int k = 0; stim.size() > 0; k++) begin
            apply("midreset", k);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                {oq, ov, oo, oa} = e.is_edge ? {qe, ve, oe, ave} : {ql, vl, ol, avl};
                n_assert++;
                if ({oq, ov, oo, oa} !== {e.q, e.v, e.o, |e.v}) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h valid=%b ovr=%b any=%b, want q=%h valid=%b ovr=%b any=%b",
                             e.tag, oq, ov, oo, oa, e.q, e.v, e.o, |e.v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_overrun();
        test_freeze();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
